// File: rtl/sample_rate_bridge_pkg.sv
// Shared definitions for the sample-rate bridge: reduction modes and the
// per-channel unsigned max used by peak detection.
package sample_rate_bridge_pkg;

    typedef enum logic {
        MODE_PICK = 1'b0,
        MODE_PEAK = 1'b1
    } mode_e;

    // Widest packed sample word the helper supports; callers zero-extend into it.
    localparam int MAX_BUS = 1024;

    function automatic logic [MAX_BUS-1:0] chan_max(
        input logic [MAX_BUS-1:0] a,
        input logic [MAX_BUS-1:0] b,
        input int                 width,
        input int                 channels
    );
        logic [MAX_BUS-1:0] r;
        logic [MAX_BUS-1:0] mask;
        logic [MAX_BUS-1:0] ca;
        logic [MAX_BUS-1:0] cb;
        r    = '0;
        mask = (MAX_BUS'(1) << width) - MAX_BUS'(1);
        for (int c = 0; c < channels; c++) begin
            ca = (a >> (c * width)) & mask;
            cb = (b >> (c * width)) & mask;
            r  = r | (((ca > cb) ? ca : cb) << (c * width));
        end
        return r;
    endfunction

endpackage

// File: rtl/sample_rate_bridge_sync_fifo.sv
// Single-clock FIFO with extended pointers; a write into a full FIFO only
// succeeds when a read frees the head slot in the same cycle.
module sync_fifo #(
    parameter int WIDTH = 24,
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       wr_en,
    input  logic [WIDTH-1:0]           wr_data,
    input  logic                       rd_en,
    output logic [WIDTH-1:0]           rd_data,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     level
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic [AW:0]      level_q, level_d;
    logic             do_wr;
    logic             do_rd;

    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign rd_data = mem[rd_ptr_q[AW-1:0]];
    assign level   = level_q;

    always_comb begin
        do_rd    = rd_en && !empty;
        do_wr    = wr_en && (!full || do_rd);
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (do_wr) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (do_rd) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        if (do_wr && !do_rd) begin
            level_d = level_q + 1'b1;
        end else if (do_rd && !do_wr) begin
            level_d = level_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    // Storage is not reset; the pointers alone define which entries are live.
    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem[wr_ptr_q[AW-1:0]] <= wr_data;
        end
    end

endmodule

// File: rtl/sample_rate_bridge.sv
// Reduces multi-channel ADC samples per window (pick-first or peak) and hands
// results to the slow readout path through a FIFO popped on out_tick.
module sample_rate_bridge
    import sample_rate_bridge_pkg::*;
#(
    parameter int WIDTH    = 12,
    parameter int CHANNELS = 2,
    parameter int DEPTH    = 8,
    parameter int DECIM_W  = 8
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        in_valid,
    input  logic [CHANNELS*WIDTH-1:0]   in_data,
    input  logic [DECIM_W-1:0]          decim,
    input  logic                        mode,
    input  logic                        out_tick,
    input  logic                        clear_err,
    output logic [CHANNELS*WIDTH-1:0]   out_data,
    output logic                        out_valid,
    output logic [$clog2(DEPTH):0]      level,
    output logic                        overflow,
    output logic                        underrun
);

    localparam int BUSW = CHANNELS * WIDTH;

    logic [DECIM_W-1:0] count_q, count_d;
    logic [DECIM_W-1:0] decim_q, decim_d;
    mode_e              mode_q, mode_d;
    logic [BUSW-1:0]    acc_q, acc_d;
    logic [BUSW-1:0]    out_data_q, out_data_d;
    logic               out_valid_q, out_valid_d;
    logic               overflow_q, overflow_d;
    logic               underrun_q, underrun_d;

    logic               first;
    logic [DECIM_W-1:0] decim_eff;
    mode_e              mode_eff;
    logic [BUSW-1:0]    peak;
    logic [BUSW-1:0]    merged;
    logic               push;
    logic               pop;
    logic [BUSW-1:0]    fifo_rd_data;
    logic               fifo_full;
    logic               fifo_empty;

    sync_fifo #(
        .WIDTH (BUSW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (push),
        .wr_data (merged),
        .rd_en   (out_tick),
        .rd_data (fifo_rd_data),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .level   (level)
    );

    // The first sample of a window uses the live controls, so a new decim/mode
    // applies from that sample onward without an extra latch cycle.
    always_comb begin
        first     = (count_q == '0);
        decim_eff = first ? decim : decim_q;
        mode_eff  = first ? mode_e'(mode) : mode_q;
        peak      = BUSW'(chan_max(MAX_BUS'(acc_q), MAX_BUS'(in_data), WIDTH, CHANNELS));
        if (first) begin
            merged = in_data;
        end else if (mode_eff == MODE_PEAK) begin
            merged = peak;
        end else begin
            merged = acc_q;
        end

        count_d = count_q;
        decim_d = decim_q;
        mode_d  = mode_q;
        acc_d   = acc_q;
        push    = 1'b0;
        if (in_valid) begin
            acc_d   = merged;
            decim_d = decim_eff;
            mode_d  = mode_eff;
            if (count_q == decim_eff) begin
                push    = 1'b1;
                count_d = '0;
            end else begin
                count_d = count_q + 1'b1;
            end
        end
    end

    // Error flags are sticky; a new event in the same cycle as clear_err wins.
    always_comb begin
        pop         = out_tick && !fifo_empty;
        out_valid_d = pop;
        out_data_d  = pop ? fifo_rd_data : out_data_q;
        overflow_d  = (overflow_q && !clear_err) || (push && fifo_full && !pop);
        underrun_d  = (underrun_q && !clear_err) || (out_tick && fifo_empty);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q     <= '0;
            decim_q     <= '0;
            mode_q      <= MODE_PICK;
            acc_q       <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            overflow_q  <= 1'b0;
            underrun_q  <= 1'b0;
        end else begin
            count_q     <= count_d;
            decim_q     <= decim_d;
            mode_q      <= mode_d;
            acc_q       <= acc_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            overflow_q  <= overflow_d;
            underrun_q  <= underrun_d;
        end
    end

    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign overflow  = overflow_q;
    assign underrun  = underrun_q;

endmodule

// File: doc/sample_rate_bridge.md
# sample_rate_bridge

Single-clock sample-rate bridge between the ADC capture path and the slower display/readout path. It accepts multi-channel samples on a valid strobe and reduces them per window by decimation or peak detect. Results are buffered in a small FIFO and released one per slow-rate tick. It is the parametrised successor to the two-clock 12-bit fast-to-slow synchroniser: the slow rate is a clock-enable strobe, so buffering, reduction modes and error flags are added.

## Interface

Parameters:
- WIDTH, 12, bits per channel sample (unsigned)
- CHANNELS, 2, channels packed in one sample word
- DEPTH, 8, FIFO entries (power of two, ≥2)
- DECIM_W, 8, width of decimation control

Ports:
- clk  in  1  single clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  in_data valid this cycle
- in_data  in  CHANNELS*WIDTH  channel 0 in LSBs
- decim  in  DECIM_W  window length minus 1 (0 = every sample)
- mode  in  1  0 = pick first sample of window, 1 = per-channel peak (max)
- out_tick  in  1  slow-rate strobe, one pop request per high cycle
- clear_err  in  1  clears sticky flags
- out_data  out  CHANNELS*WIDTH  last popped word
- out_valid  out  1  one-cycle pulse, out_data updated
- level  out  $clog2(DEPTH)+1  FIFO occupancy
- overflow  out  1  sticky: window result dropped, FIFO full
- underrun  out  1  sticky: out_tick while FIFO empty

## Operation

- Reset values: out_data 0, out_valid 0, level 0, overflow 0, underrun 0, window count 0, accumulators 0.
- Window:
  - decim and mode are latched at the first accepted sample of each window.
  - Changes mid-window take effect at the next window.
  - The window counter counts in_valid cycles from 0 to the latched decim, then wraps to 0.
- Pick mode: the first sample of the window is stored.
- Peak mode:
  - Each channel accumulator loads the first sample, then takes the unsigned max with each later sample.
  - The result of the last sample includes that sample.
- Window end (in_valid with count == latched decim): the result is pushed to the FIFO. The accumulator is reloaded from the next window's first sample, with no idle cycle.
- Pop:
  - out_tick with level>0 pops the head into out_data and pulses out_valid.
  - out_tick with level==0 sets underrun. out_data holds and out_valid stays 0.
- Full:
  - A push with level==DEPTH and no pop is dropped and sets overflow. The FIFO is unchanged.
  - Push and pop in the same cycle while full both succeed, and level stays DEPTH.
- Empty with simultaneous push and tick: there is no bypass. The tick sees empty, underrun is set, and the push lands (level 1).
- clear_err clears both flags. If an error event occurs in the same cycle, the flag stays set (set wins).
- When rst_n is asserted mid-operation, all state clears immediately and the partial window is discarded.

## Timing

- All outputs are registered.
- Push latency: the window-end sample at edge t makes level increment at edge t.
- Pop: out_tick sampled high at edge k (level>0) updates out_data and pulses out_valid at edge k. out_valid is high for exactly one cycle.
- Minimum end-to-end: window end at edge t, then out_tick at edge t+1 gives out_data at edge t+1.
- Throughput: one window result per cycle when decim=0, and one pop per cycle.
- level updates in the same edge as the push/pop: +1, −1, or 0 for both or neither.

## Structure

- Package sample_rate_bridge_pkg holds:
  - the MODE_PICK/MODE_PEAK constants
  - a helper function for unsigned per-channel max over the packed word
- Sub-module sync_fifo (parameters WIDTH=CHANNELS*WIDTH, DEPTH):
  - wraparound read/write pointers with an extra MSB for full/empty
  - exposes level
  - drops writes when full unless a read happens in the same cycle
- The top level holds the window counter, latched controls, accumulators and sticky flags.

## Test plan

- Reset/pick, decim=0: push 0x0FF/0x123 and tick one cycle later → out_data={0x123,0x0FF}, out_valid one cycle, level back to 0.
- Pick, decim=3, samples ch0=1,2,3,4: window result 1; five more samples produce no second push until the 8th sample.
- Peak, decim=3, ch0 = 5,0xFFF,7,2 and ch1 = 9,1,0xA00,3: result {0xA00,0xFFF}.
- Overflow, DEPTH=8, 9 windows, no ticks: level=8, overflow=1, and the 9th result is lost. Then push+tick in the same cycle → level stays 8.
- Underrun and clear: tick on empty → underrun=1, out_valid=0, out_data unchanged. clear_err coinciding with another empty tick → underrun stays 1. A lone clear_err then clears it.
- Reset mid-window, peak, decim=7: after 4 samples assert rst_n → all outputs 0. The next 8 samples form a fresh window.
